// File: rtl/dnn_pkg.sv
// Shared types and default latencies for the DNN training-sequence controller.
package dnn_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StFwd,
        StLatch,
        StBwd,
        StUpd,
        StNext,
        StDone
    } dnn_ctrl_state_t;

    localparam int unsigned DNN_FWD_LAT = 3;
    localparam int unsigned DNN_BWD_LAT = 3;

    function automatic int unsigned dnn_max(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lat_cnt.sv
// Loadable up/down cycle counter with a terminal-count flag; shared by the
// forward and backward phases of the training controller.
module lat_cnt #(
    parameter int unsigned W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    input  logic         down_i,
    input  logic [W-1:0] term_i,
    output logic         tc_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i) begin
            cnt_d = down_i ? (cnt_q - W'(1)) : (cnt_q + W'(1));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == term_i);

endmodule

// File: rtl/dnn_train_ctrl.sv
// Training-sequence controller: fetch, forward timing, load, backward phase, weight write.
// Optional inference-only mode when DNN_CTRL_INFER_EN is defined.
module dnn_train_ctrl
    import dnn_pkg::*;
#(
    parameter int unsigned FWD_LAT  = DNN_FWD_LAT,
    parameter int unsigned BWD_LAT  = DNN_BWD_LAT,
    parameter int unsigned N_SAMPLE = 4,
    parameter int unsigned EP_W     = 8,
    localparam int unsigned SW      = (N_SAMPLE > 1) ? $clog2(N_SAMPLE) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic [EP_W-1:0] n_epoch,
`ifdef DNN_CTRL_INFER_EN
    input  logic            infer,
`endif
    input  logic            i_valid,
    output logic            o_ready,
    output logic            load,
    output logic            bwd_en,
    output logic            wr,
    output logic [SW-1:0]   sample_idx,
    output logic [EP_W-1:0] epoch_idx,
    output logic            busy,
    output logic            done
);

    localparam int unsigned CW = $clog2(dnn_max(FWD_LAT, BWD_LAT)) + 1;

    dnn_ctrl_state_t state_q, state_d;
    logic [EP_W-1:0] n_ep_q, n_ep_d;
    logic [EP_W-1:0] epoch_q, epoch_d;
    logic [SW-1:0]   sample_q, sample_d;
    logic            infer_q;

    logic            cnt_load, cnt_en, cnt_tc;
    logic [CW-1:0]   cnt_term;
    logic            sample_last, epoch_last;
    logic [EP_W:0]   epoch_inc;

`ifdef DNN_CTRL_INFER_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            infer_q <= 1'b0;
        end else if (state_q == StIdle && start && !abort) begin
            infer_q <= infer;
        end
    end
`else
    assign infer_q = 1'b0;
`endif

    // One counter serves both phases; the terminal value follows the phase.
    assign cnt_term = (state_q == StBwd) ? CW'(BWD_LAT - 1) : CW'(FWD_LAT - 1);

    lat_cnt #(
        .W (CW)
    ) u_lat_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load),
        .load_val_i ('0),
        .en_i       (cnt_en),
        .down_i     (1'b0),
        .term_i     (cnt_term),
        .tc_o       (cnt_tc)
    );

    assign sample_last = (sample_q == SW'(N_SAMPLE - 1));
    assign epoch_inc   = {1'b0, epoch_q} + (EP_W + 1)'(1);
    assign epoch_last  = (epoch_inc >= {1'b0, n_ep_q});

    always_comb begin
        state_d  = state_q;
        n_ep_d   = n_ep_q;
        epoch_d  = epoch_q;
        sample_d = sample_q;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
        load     = 1'b0;
        bwd_en   = 1'b0;
        wr       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    n_ep_d   = (n_epoch == '0) ? EP_W'(1) : n_epoch;
                    epoch_d  = '0;
                    sample_d = '0;
                    state_d  = StFetch;
                end
            end
            StFetch: begin
                if (i_valid) begin
                    cnt_load = 1'b1;
                    state_d  = StFwd;
                end
            end
            StFwd: begin
                if (cnt_tc) begin
                    state_d = StLatch;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            StLatch: begin
                load     = 1'b1;
                cnt_load = 1'b1;
                state_d  = infer_q ? StNext : StBwd;
            end
            StBwd: begin
                bwd_en = 1'b1;
                if (cnt_tc) begin
                    state_d = StUpd;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            StUpd: begin
                wr      = 1'b1;
                state_d = StNext;
            end
            StNext: begin
                if (sample_last) begin
                    sample_d = '0;
                    if (epoch_q != '1) begin
                        epoch_d = epoch_inc[EP_W-1:0];
                    end
                    state_d = epoch_last ? StDone : StFetch;
                end else begin
                    sample_d = sample_q + SW'(1);
                    state_d  = StFetch;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Abort wins over everything but leaves the indices where they were.
        if (abort) begin
            state_d  = StIdle;
            n_ep_d   = n_ep_q;
            epoch_d  = epoch_q;
            sample_d = sample_q;
            load     = 1'b0;
            bwd_en   = 1'b0;
            wr       = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            n_ep_q   <= '0;
            epoch_q  <= '0;
            sample_q <= '0;
        end else begin
            state_q  <= state_d;
            n_ep_q   <= n_ep_d;
            epoch_q  <= epoch_d;
            sample_q <= sample_d;
        end
    end

    assign o_ready    = (state_q == StFetch);
    assign busy       = (state_q != StIdle);
    assign done       = (state_q == StDone);
    assign sample_idx = sample_q;
    assign epoch_idx  = epoch_q;

endmodule

// File: tb/tb_dnn_train_ctrl.sv
// Directed bench for dnn_train_ctrl with default parameters.
module tb_dnn_train_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       i_valid = 1'b0;
    logic [7:0] n_epoch = 8'd0;
`ifdef DNN_CTRL_INFER_EN
    logic       infer = 1'b0;
`endif
    logic       o_ready, load, bwd_en, wr, busy, done;
    logic [1:0] sample_idx;
    logic [7:0] epoch_idx;

    int checks = 0;
    int failures = 0;

    logic       ld_a [0:127];
    logic       wr_a [0:127];
    logic       bw_a [0:127];
    logic       dn_a [0:127];
    logic       rd_a [0:127];
    logic       by_a [0:127];
    logic [1:0] si_a [0:127];
    logic [7:0] ei_a [0:127];
    int n_ld, n_wr, n_bw, n_dn;

    always #5 clk = ~clk;

    dnn_train_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .n_epoch    (n_epoch),
`ifdef DNN_CTRL_INFER_EN
        .infer      (infer),
`endif
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .load       (load),
        .bwd_en     (bwd_en),
        .wr         (wr),
        .sample_idx (sample_idx),
        .epoch_idx  (epoch_idx),
        .busy       (busy),
        .done       (done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Capture cycles 0..n, where cycle 0 is the current one.
    task automatic record(input int n);
        n_ld = 0; n_wr = 0; n_bw = 0; n_dn = 0;
        for (int k = 0; k <= n; k++) begin
            if (k > 0) tick();
            ld_a[k] = load;    wr_a[k] = wr;     bw_a[k] = bwd_en;
            dn_a[k] = done;    rd_a[k] = o_ready; by_a[k] = busy;
            si_a[k] = sample_idx; ei_a[k] = epoch_idx;
            n_ld += int'(load); n_wr += int'(wr); n_bw += int'(bwd_en); n_dn += int'(done);
        end
    endtask

    initial begin
        #3;
        chk("rst_async_outs", {o_ready, load, bwd_en, wr, busy, done, sample_idx, epoch_idx}, 0);
        #10 rst = 1'b1;
        tick();
        chk("reset_idle_outs", {o_ready, load, bwd_en, wr, busy, done, sample_idx, epoch_idx}, 0);

        // Start, then stall in FETCH for 5 cycles.
        n_epoch = 8'd1; start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_ready", o_ready, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_ready", o_ready, 1);
            chk("stall_noload", load, 0);
        end

        // One epoch, i_valid held high; cycle 0 is the first accept cycle.
        i_valid = 1'b1;
        record(41);
        chk("e1_load_cnt", n_ld, 4);
        chk("e1_load_at", {ld_a[4], ld_a[14], ld_a[24], ld_a[34]}, 4'b1111);
        chk("e1_wr_cnt", n_wr, 4);
        chk("e1_wr_at", {wr_a[8], wr_a[18], wr_a[28], wr_a[38]}, 4'b1111);
        chk("e1_bwd_cnt", n_bw, 12);
        chk("e1_bwd_edges", {bw_a[4], bw_a[5], bw_a[7], bw_a[8]}, 4'b0110);
        chk("e1_ready_ret", {rd_a[9], rd_a[10], rd_a[11]}, 3'b010);
        chk("e1_sidx", {si_a[4], si_a[14], si_a[24], si_a[34]}, 8'b00_01_10_11);
        chk("e1_done_cnt", n_dn, 1);
        chk("e1_done_at", {dn_a[39], dn_a[40]}, 2'b01);
        chk("e1_busy_fall", {by_a[40], by_a[41]}, 2'b10);
        chk("e1_final_idx", {si_a[41], ei_a[41]}, {2'd0, 8'd1});

        // Two epochs.
        n_epoch = 8'd2; start = 1'b1;
        tick();
        start = 1'b0;
        record(81);
        chk("e2_idx_cleared", {si_a[0], ei_a[0]}, 0);
        chk("e2_wr_cnt", n_wr, 8);
        chk("e2_epoch_step", {ei_a[39], ei_a[40]}, {8'd0, 8'd1});
        chk("e2_done_cnt", n_dn, 1);
        chk("e2_done_at", dn_a[80], 1);
        chk("e2_final", {by_a[81], ei_a[81]}, {1'b0, 8'd2});

        // Abort during the backward phase of sample 1.
        n_epoch = 8'd1; start = 1'b1;
        tick();
        start = 1'b0;
        record(16);
        chk("ab_in_bwd", {bw_a[16], si_a[16]}, {1'b1, 2'd1});
        abort = 1'b1;
        #1;
        chk("ab_forced_low", {wr, bwd_en, load}, 0);
        tick();
        abort = 1'b0;
        chk("ab_idle", {busy, o_ready}, 0);
        record(10);
        chk("ab_no_wr", n_wr + n_ld + n_bw, 0);
        chk("ab_idx_kept", si_a[0], 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ab_restart", {o_ready, sample_idx, epoch_idx}, {1'b1, 2'd0, 8'd0});
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_second_idle", busy, 0);

        // n_epoch = 0 runs a single epoch.
        n_epoch = 8'd0; start = 1'b1;
        tick();
        start = 1'b0;
        record(41);
        chk("e0_wr_cnt", n_wr, 4);
        chk("e0_done", {n_dn, 31'(dn_a[40])}, {32'd1, 31'd1});
        chk("e0_epoch", {by_a[41], ei_a[41]}, {1'b0, 8'd1});

`ifdef DNN_CTRL_INFER_EN
        infer = 1'b1; n_epoch = 8'd1; start = 1'b1;
        tick();
        start = 1'b0; infer = 1'b0;
        record(25);
        chk("inf_load_at", {ld_a[4], ld_a[10], ld_a[16], ld_a[22]}, 4'b1111);
        chk("inf_load_cnt", n_ld, 4);
        chk("inf_no_train", n_wr + n_bw, 0);
        chk("inf_done", dn_a[24], 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
